// File: rtl/adder_share_ctrl_pkg.sv
// adder_share_ctrl_pkg: shared encodings and defaults for the adder-sharing controller
package adder_share_ctrl_pkg;
  localparam int ADD_W = 4;
  localparam int CNT_W = 4;
  // Three cycles of a 25-unit clock cover the adder's 60-unit worst-case carry ripple
  localparam int DEF_SETTLE_CYCLES = 3;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;
endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first set request after the last winner
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Scan last+1, last+2, ... modulo NREQ and keep the first requester found
  always_comb begin
    int c;
    logic found;
    gnt = '0;
    idx = '0;
    found = 1'b0;
    c = 0;
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(last) + k) % NREQ;
      if (!found && req[c[IW-1:0]]) begin
        found = 1'b1;
        gnt[c[IW-1:0]] = 1'b1;
        idx = IDW'(c);
      end
    end
  end
endmodule

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: time-shares one external 4-bit ripple adder among NREQ requesters
module adder_share_ctrl
  import adder_share_ctrl_pkg::*;
#(
  parameter int NREQ          = 4,
  parameter int IDW           = 2,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [ADD_W*NREQ-1:0] req_a,
  input  logic [ADD_W*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [ADD_W-1:0]      add_a,
  output logic [ADD_W-1:0]      add_b,
  output logic                  add_cin,
  input  logic [ADD_W-1:0]      add_sum,
  input  logic                  add_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADD_W-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);
  state_e            state_q, state_d;
  logic [IDW-1:0]    last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADD_W-1:0]  add_a_q, add_a_d, add_b_q, add_b_d;
  logic              add_cin_q, add_cin_d;
  logic [ADD_W-1:0]  rsp_sum_q, rsp_sum_d;
  logic              rsp_cout_q, rsp_cout_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [NREQ-1:0]   arb_req, gnt;
  logic [IDW-1:0]    gnt_idx;
  logic [ADD_W-1:0]  sel_a, sel_b;
  logic              sel_cin;

  // Arbitration only runs in IDLE and out of reset, so req_ready is zero otherwise
  assign arb_req = (state_q == ST_IDLE && rst_n) ? req_valid : '0;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req  (arb_req),
    .last (last_q),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  assign req_ready = gnt;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = state_q != ST_IDLE;

  // Steer the winning requester's operands toward the adder input registers
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sel_a |= gnt[i] ? req_a[ADD_W*i +: ADD_W] : '0;
      sel_b |= gnt[i] ? req_b[ADD_W*i +: ADD_W] : '0;
      sel_cin |= gnt[i] & req_cin[i];
    end
  end

  // Next-state: accept in IDLE, count down the settle window, hold result until taken
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    cnt_d = cnt_q;
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    add_cin_d = add_cin_q;
    rsp_sum_d = rsp_sum_q;
    rsp_cout_d = rsp_cout_q;
    rsp_id_d = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          add_a_d = sel_a;
          add_b_d = sel_b;
          add_cin_d = sel_cin;
          rsp_id_d = gnt_idx;
          last_d = gnt_idx;
          cnt_d = CNT_W'(SETTLE_CYCLES - 1);
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          cnt_d = '0;
          rsp_sum_d = add_sum;
          rsp_cout_d = add_cout;
          rsp_valid_d = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q <= IDW'(NREQ - 1);
      cnt_q <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
      add_cin_q <= 1'b0;
      rsp_sum_q <= '0;
      rsp_cout_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      add_cin_q <= add_cin_d;
      rsp_sum_q <= rsp_sum_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_id_q <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb_adder_share_ctrl: table-driven and scoreboard checks of the adder-sharing controller
module tb_adder_share_ctrl;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] req_valid, req_ready, req_cin;
  logic [4*NREQ-1:0] req_a, req_b;
  logic [3:0] add_a, add_b, add_sum, rsp_sum;
  logic add_cin, add_cout, rsp_valid, rsp_ready, rsp_cout, busy;
  logic [IDW-1:0] rsp_id;
  wire [4:0] add_res;

  logic [1:0] s_req_valid, s_req_ready, s_req_cin;
  logic [7:0] s_req_a, s_req_b;
  logic [3:0] s_add_a, s_add_b, s_add_sum, s_rsp_sum;
  logic s_add_cin, s_add_cout, s_rsp_valid, s_rsp_ready, s_rsp_cout, s_busy;
  logic [0:0] s_rsp_id;
  wire [4:0] s_add_res;

  // Delay-annotated ripple adders: result appears 60 time units after inputs change
  assign #60 add_res = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
  assign add_sum = add_res[3:0];
  assign add_cout = add_res[4];
  assign #60 s_add_res = {1'b0, s_add_a} + {1'b0, s_add_b} + {4'd0, s_add_cin};
  assign s_add_sum = s_add_res[3:0];
  assign s_add_cout = s_add_res[4];

  adder_share_ctrl #(.NREQ(NREQ), .IDW(IDW), .SETTLE_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id), .busy(busy)
  );

  adder_share_ctrl #(.NREQ(2), .IDW(1), .SETTLE_CYCLES(1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_a(s_req_a), .req_b(s_req_b), .req_cin(s_req_cin), .add_a(s_add_a), .add_b(s_add_b),
    .add_cin(s_add_cin), .add_sum(s_add_sum), .add_cout(s_add_cout), .rsp_valid(s_rsp_valid),
    .rsp_ready(s_rsp_ready), .rsp_sum(s_rsp_sum), .rsp_cout(s_rsp_cout), .rsp_id(s_rsp_id), .busy(s_busy)
  );

  always begin
    #12 clk = 1'b1;
    #13 clk = 1'b0;
  end

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [3:0]     sum;
    logic           cout;
  } exp_t;

  typedef struct {
    int         id;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       co;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int errors = 0;
  int checks = 0;

  function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {4'd0, cin};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input int id, input logic [3:0] s, input logic co);
    exp_t e;
    e.id = IDW'(id);
    e.sum = s;
    e.cout = co;
    sb.push_back(e);
  endtask

  task automatic wait_grant(input string nm);
    for (int i = 0; i < 30 && req_ready == '0; i++) cyc();
    if (req_ready == '0) chk({nm, "_grant_timeout"}, 32'(req_ready), 32'hFFFF_FFFF);
  endtask

  task automatic wait_rsp(input string nm, output int lat);
    lat = 0;
    while (!rsp_valid && lat < 30) begin
      cyc();
      lat++;
    end
    if (!rsp_valid) chk({nm, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic check_rsp(input string nm);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected response id=%0d sum=%0h, scoreboard empty", nm, rsp_id, rsp_sum);
      return;
    end
    checks--;
    e = sb.pop_front();
    chk({nm, "_id"}, 32'(rsp_id), 32'(e.id));
    chk({nm, "_sum"}, 32'(rsp_sum), 32'(e.sum));
    chk({nm, "_cout"}, 32'(rsp_cout), 32'(e.cout));
  endtask

  task automatic run_single(input int id, input logic [3:0] a, input logic [3:0] b, input logic cin,
                            input logic [3:0] es, input logic ec);
    int lat;
    req_a[4*id +: 4] = a;
    req_b[4*id +: 4] = b;
    req_cin[id] = cin;
    req_valid = NREQ'(1 << id);
    #1;
    chk("single_grant", 32'(req_ready), 32'(1 << id));
    push_exp(id, es, ec);
    cyc();
    chk("single_ready_drop", 32'(req_ready), 32'd0);
    chk("single_busy", 32'(busy), 32'd1);
    req_valid = '0;
    wait_rsp("single", lat);
    chk("single_latency", 32'(lat), 32'd3);
    check_rsp("single_rsp");
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("single_idle", {30'd0, busy, rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [4:0] r, prev;
    req_valid = '0; req_cin = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    s_req_valid = '0; s_req_cin = '0; s_req_a = '0; s_req_b = '0; s_rsp_ready = 1'b0;
    tbl[0] = '{2, 4'h7, 4'h9, 1'b0, 4'h0, 1'b1};
    tbl[1] = '{0, 4'hF, 4'h0, 1'b1, 4'h0, 1'b1};
    tbl[2] = '{1, 4'h3, 4'h4, 1'b1, 4'h8, 1'b0};
    tbl[3] = '{3, 4'h5, 4'h5, 1'b0, 4'hA, 1'b0};
    tbl[4] = '{0, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    tbl[5] = '{2, 4'h8, 4'h8, 1'b0, 4'h0, 1'b1};
    tbl[6] = '{1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
    tbl[7] = '{3, 4'hC, 4'h3, 1'b0, 4'hF, 1'b0};
    cyc();
    cyc();
    chk("reset_state", {add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy, req_ready},
        32'd0);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 8; i++) run_single(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co);

    // All requesters continuously valid: last grant was 3, so order is 0,1,2,3,0
    for (int i = 0; i < NREQ; i++) begin
      req_a[4*i +: 4] = 4'(i * 3 + 1);
      req_b[4*i +: 4] = 4'(i * 5 + 7);
      req_cin[i] = i[0];
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      wait_grant("rr");
      chk("rr_order", 32'(req_ready), 32'(1 << (k % NREQ)));
      r = model(req_a[4*(k%NREQ) +: 4], req_b[4*(k%NREQ) +: 4], req_cin[k%NREQ]);
      push_exp(k % NREQ, r[3:0], r[4]);
      cyc();
      wait_rsp("rr", lat);
      check_rsp("rr_rsp");
      cyc();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    cyc();

    // Backpressure with requester 1 waiting
    req_a[3:0] = 4'h2; req_b[3:0] = 4'h3; req_cin[0] = 1'b0;
    req_a[7:4] = 4'h9; req_b[7:4] = 4'h9; req_cin[1] = 1'b1;
    req_valid = 4'b0001;
    #1;
    chk("bp_first_grant", 32'(req_ready), 32'd1);
    push_exp(0, 4'h5, 1'b0);
    cyc();
    req_valid = 4'b0010;
    wait_rsp("bp", lat);
    check_rsp("bp_rsp0");
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bp_hold", {rsp_valid, busy, req_ready, rsp_id, rsp_sum, rsp_cout},
          {1'b1, 1'b1, 4'b0000, 2'd0, 4'h5, 1'b0});
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_handshake_no_grant", 32'(req_ready), 32'd0);
    cyc();
    rsp_ready = 1'b0;
    chk("bp_grant_after_idle", {27'd0, rsp_valid, req_ready}, {27'd0, 1'b0, 4'b0010});
    push_exp(1, 4'h3, 1'b1);
    cyc();
    req_valid = '0;
    wait_rsp("bp1", lat);
    check_rsp("bp_rsp1");
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;

    // Reset two cycles into DRIVE
    req_a[11:8] = 4'h6; req_b[11:8] = 4'h6; req_cin[2] = 1'b0;
    req_valid = 4'b0100;
    #1;
    chk("rst_pre_grant", 32'(req_ready), 32'd4);
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    chk("rst_in_drive", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_outputs_zero", {add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy, req_ready},
        32'd0);
    sb.delete();
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("rst_no_rsp", {30'd0, rsp_valid, busy}, 32'd0);
    end
    req_a[3:0] = 4'hA; req_b[3:0] = 4'h7; req_cin[0] = 1'b1;
    req_valid = '1;
    #1;
    chk("rst_next_grant", 32'(req_ready), 32'd1);
    r = model(4'hA, 4'h7, 1'b1);
    push_exp(0, r[3:0], r[4]);
    cyc();
    req_valid = '0;
    wait_rsp("rst", lat);
    check_rsp("rst_rsp");
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Settle window too short: capture sees the adder output from the previous operands
    prev = 5'd0;
    for (int k = 0; k < 2; k++) begin
      s_req_a[4*k +: 4] = (k == 0) ? 4'h1 : 4'h5;
      s_req_b[4*k +: 4] = (k == 0) ? 4'h2 : 4'h6;
      s_req_cin[k] = 1'b0;
      s_req_valid = 2'(1 << k);
      #1;
      chk("fast_grant", 32'(s_req_ready), 32'(1 << k));
      r = model(s_req_a[4*k +: 4], s_req_b[4*k +: 4], 1'b0);
      cyc();
      s_req_valid = '0;
      lat = 0;
      while (!s_rsp_valid && lat < 30) begin
        cyc();
        lat++;
      end
      chk("fast_latency", 32'(lat), 32'd1);
      chk("fast_stale_capture", {27'd0, s_rsp_cout, s_rsp_sum}, {27'd0, prev});
      if ({s_rsp_cout, s_rsp_sum} != r)
        $display("note: settle=1 captured stale %0h instead of settled %0h", {s_rsp_cout, s_rsp_sum}, r);
      prev = r;
      s_rsp_ready = 1'b1;
      cyc();
      s_rsp_ready = 1'b0;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
